sqrt_pipe_tail: RTL and testbench

//  Consumer end of the square-root pipeline's stage-2 register interface.
//  - Completes the split add: high byte sum = A_high + B_high + Co.
//  - Buffers finished results in a small FIFO for a valid/ready consumer.
//  - Drives en_pipe_o back to the upstream stage registers as back-pressure.

---
 rtl/sqrt_pkg.sv | 23 ++
 rtl/sqrt_tail_fifo.sv | 60 ++++++
 rtl/sqrt_pipe_tail.sv | 79 +++++++
 tb/tb_sqrt_pipe_tail.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared widths, result record and the high-byte add for the sqrt pipeline tail.
package sqrt_pkg;

    localparam int SUM_LOW_W = 9;
    localparam int HALF_W    = 8;
    localparam int RES_W     = 18;

    typedef struct packed {
        logic [RES_W-1:0] sum;
        logic             n;
        logic             n2;
    } sqrt_res_t;

    // 8+8+1 bit add widened to 9 bits so 255+255+1 keeps its carry
    function automatic logic [SUM_LOW_W-1:0] high_add(
        input logic [HALF_W-1:0] a,
        input logic [HALF_W-1:0] b,
        input logic              co
    );
        return {1'b0, a} + {1'b0, b} + {{HALF_W{1'b0}}, co};
    endfunction

endpackage

// File: rtl/sqrt_tail_fifo.sv
// DEPTH-entry result FIFO (power-of-two depth) with read/write pointers and occupancy count.
module sqrt_tail_fifo
    import sqrt_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  sqrt_res_t wr_data,
    output sqrt_res_t rd_data,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    sqrt_res_t        entry_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Power-of-two depth lets the pointers wrap by plain overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            count_reg <= count_next;
            if (push) begin
                entry_reg[wr_ptr_reg] <= wr_data;
                wr_ptr_reg            <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    assign rd_data = entry_reg[rd_ptr_reg];
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);

endmodule

// File: rtl/sqrt_pipe_tail.sv
// Tail of the sqrt pipeline: finishes the split high add, queues results, back-pressures upstream.
// Optional stalled-offer counter enabled by defining SQRT_TAIL_STALL_STATS_EN.
module sqrt_pipe_tail
    import sqrt_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ready_i,
    output logic                 en_pipe_o,
    input  logic                 N_i,
    input  logic                 N2_i,
    input  logic [SUM_LOW_W-1:0] sum_low_i,
    input  logic                 Co_i,
    input  logic [HALF_W-1:0]    A_high_i,
    input  logic [HALF_W-1:0]    B_high_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [RES_W-1:0]     res_sum_o,
    output logic                 res_N_o,
    output logic                 res_N2_o,
    output logic                 res_zero_o,
    output logic [15:0]          stall_cnt_o
);

    logic      fifo_full;
    logic      fifo_empty;
    logic      push;
    logic      pop;
    sqrt_res_t wr_data;
    sqrt_res_t rd_data;

    // Flow control comes only from registered occupancy, never from the ready inputs
    assign en_pipe_o   = ~fifo_full;
    assign res_valid_o = ~fifo_empty;
    assign push        = ready_i & en_pipe_o;
    assign pop         = res_valid_o & res_ready_i;

    assign wr_data.sum = {high_add(A_high_i, B_high_i, Co_i), sum_low_i};
    assign wr_data.n   = N_i;
    assign wr_data.n2  = N2_i;

    sqrt_tail_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign res_sum_o  = rd_data.sum;
    assign res_N_o    = rd_data.n;
    assign res_N2_o   = rd_data.n2;
    assign res_zero_o = (rd_data.sum == '0);

`ifdef SQRT_TAIL_STALL_STATS_EN
    logic [15:0] stall_cnt_reg;

    // Counts offers refused while full; saturates rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (ready_i && !en_pipe_o && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
`else
    assign stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_sqrt_pipe_tail.sv
// Self-checking bench for sqrt_pipe_tail: directed cases plus a scoreboarded random phase.
module tb_sqrt_pipe_tail;
    import sqrt_pkg::*;

    localparam int DEPTH = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 ready_i;
    logic                 en_pipe_o;
    logic                 N_i;
    logic                 N2_i;
    logic [SUM_LOW_W-1:0] sum_low_i;
    logic                 Co_i;
    logic [HALF_W-1:0]    A_high_i;
    logic [HALF_W-1:0]    B_high_i;
    logic                 res_valid_o;
    logic                 res_ready_i;
    logic [RES_W-1:0]     res_sum_o;
    logic                 res_N_o;
    logic                 res_N2_o;
    logic                 res_zero_o;
    logic [15:0]          stall_cnt_o;

    int check_cnt = 0;
    int error_cnt = 0;

    logic [19:0] exp_q[$];
    int          model_cnt  = 0;
    int          model_stall = 0;

    sqrt_pipe_tail #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ready_i     (ready_i),
        .en_pipe_o   (en_pipe_o),
        .N_i         (N_i),
        .N2_i        (N2_i),
        .sum_low_i   (sum_low_i),
        .Co_i        (Co_i),
        .A_high_i    (A_high_i),
        .B_high_i    (B_high_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_sum_o   (res_sum_o),
        .res_N_o     (res_N_o),
        .res_N2_o    (res_N2_o),
        .res_zero_o  (res_zero_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic co,
                         input logic [8:0] sl, input logic n, input logic n2);
        ready_i   = v;
        A_high_i  = a;
        B_high_i  = b;
        Co_i      = co;
        sum_low_i = sl;
        N_i       = n;
        N2_i      = n2;
    endtask

    // Scoreboard: compare head on a pop, then record any push; inputs are stable at negedge
    always @(negedge clk) begin
        logic [19:0] e;
        logic [8:0]  hs;
        if (!rst_n) begin
            model_cnt   = 0;
            model_stall = 0;
            exp_q.delete();
        end else begin
            check("en_pipe", 32'(en_pipe_o), 32'(model_cnt != DEPTH));
            check("res_valid", 32'(res_valid_o), 32'(model_cnt != 0));
            check("stall_cnt", 32'(stall_cnt_o), 32'(model_stall));
            if (res_valid_o && res_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_sum", 32'(res_sum_o), 32'(e[19:2]));
                    check("res_N", 32'(res_N_o), 32'(e[1]));
                    check("res_N2", 32'(res_N2_o), 32'(e[0]));
                    check("res_zero", 32'(res_zero_o), 32'(e[19:2] == 18'd0));
                    $display("pop  sum=0x%05h N=%0b N2=%0b", res_sum_o, res_N_o, res_N2_o);
                end
            end
            if (ready_i && (model_cnt != DEPTH)) begin
                hs = 9'(A_high_i) + 9'(B_high_i) + 9'(Co_i);
                exp_q.push_back({hs, sum_low_i, N_i, N2_i});
                $display("push A=0x%02h B=0x%02h Co=%0b low=0x%03h", A_high_i, B_high_i, Co_i, sum_low_i);
            end
`ifdef SQRT_TAIL_STALL_STATS_EN
            if (ready_i && (model_cnt == DEPTH) && model_stall != 65535) model_stall++;
`endif
            model_cnt = model_cnt + ((ready_i && model_cnt != DEPTH) ? 1 : 0)
                                  - ((model_cnt != 0 && res_ready_i) ? 1 : 0);
        end
    end

    initial begin
        rst_n       = 1'b0;
        res_ready_i = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0);

        // 1: reset and idle
        @(negedge clk);
        check("rst_en", 32'(en_pipe_o), 32'd1);
        check("rst_valid", 32'(res_valid_o), 32'd0);
        check("rst_zero", 32'(res_zero_o), 32'd1);
        check("rst_sum", 32'(res_sum_o), 32'd0);
        check("rst_stall", 32'(stall_cnt_o), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check("idle_en", 32'(en_pipe_o), 32'd1);
        check("idle_valid", 32'(res_valid_o), 32'd0);

        // 2: single push, latency 1, consumed next cycle
        res_ready_i = 1'b1;
        drive(1'b1, 8'h12, 8'h34, 1'b1, 9'h1FF, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0);
        @(negedge clk);
        check("t2_valid", 32'(res_valid_o), 32'd1);
        check("t2_sum", 32'(res_sum_o), 32'h08FFF);
        check("t2_N", 32'(res_N_o), 32'd1);
        step();
        @(negedge clk);
        check("t2_valid_after", 32'(res_valid_o), 32'd0);

        // 3: carry into bit 8 of the high sum
        drive(1'b1, 8'hFF, 8'hFF, 1'b1, 9'h000, 1'b0, 1'b1);
        step();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0);
        @(negedge clk);
        check("t3_sum", 32'(res_sum_o), 32'h3FE00);
        check("t3_N2", 32'(res_N2_o), 32'd1);
        step();

        // 4: all-zero result
        drive(1'b1, 8'h00, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0);
        @(negedge clk);
        check("t4_valid", 32'(res_valid_o), 32'd1);
        check("t4_sum", 32'(res_sum_o), 32'd0);
        check("t4_zero", 32'(res_zero_o), 32'd1);
        step();

        // 5: fill to full with consumer stalled, then drain
        res_ready_i = 1'b0;
        drive(1'b1, 8'h01, 8'h02, 1'b0, 9'h011, 1'b0, 1'b1);
        step();
        drive(1'b1, 8'h10, 8'h20, 1'b1, 9'h022, 1'b1, 1'b0);
        step();
        @(negedge clk);
        check("t5_full_en", 32'(en_pipe_o), 32'd0);
        drive(1'b1, 8'hAA, 8'h55, 1'b1, 9'h033, 1'b1, 1'b1);
        step();
        step();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0);
        res_ready_i = 1'b1;
`ifdef SQRT_TAIL_STALL_STATS_EN
        check("t5_stall", 32'(stall_cnt_o), 32'd2);
`else
        check("t5_stall", 32'(stall_cnt_o), 32'd0);
`endif
        @(negedge clk);
        check("t5_still_full", 32'(en_pipe_o), 32'd0);
        step();
        @(negedge clk);
        check("t5_en_back", 32'(en_pipe_o), 32'd1);
        step();
        step();
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // Random traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom),
                  9'($urandom), 1'($urandom), 1'($urandom));
            res_ready_i = ($urandom_range(0, 3) != 0);
            step();
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0);
        res_ready_i = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 2; i++) step();
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        // 6: async reset with one entry queued
        res_ready_i = 1'b0;
        drive(1'b1, 8'h33, 8'h44, 1'b0, 9'h155, 1'b1, 1'b1);
        step();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0);
        #2;
        check("t6_valid_before", 32'(res_valid_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_valid_async", 32'(res_valid_o), 32'd0);
        check("t6_sum_async", 32'(res_sum_o), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        check("t6_valid_post", 32'(res_valid_o), 32'd0);
        check("t6_en_post", 32'(en_pipe_o), 32'd1);
        check("t6_zero_post", 32'(res_zero_o), 32'd1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule
